ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Parametrised instruction-fetch unit: a word-organised instruction memory, a program counter, a registered instruction output with valid/stall handshake, branch redirect, a program-load port, and a boot/run/halt state machine. It sits at the front of the processor pipeline and replaces the fixed-size, free-running fetch block. Addresses are byte addresses over a window starting at `BASE_ADDR`. Instructions are little-endian words.

## Interface
- `BASE_ADDR`, 32'h0040_0000, byte address of word 0 and the PC reset value
- `DEPTH_WORDS`, 1024, number of 32-bit words in memory; power of two, at least 4
- `AW`, 32, width of PC and all address ports
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `stall`  in  1  downstream not ready; hold `inst`, `pc_out`, `inst_valid` and PC
- `redirect_valid`  in  1  load PC from `redirect_pc` this cycle
- `redirect_pc`  in  AW  branch/jump target, byte address
- `load_we`  in  1  program-load write strobe
- `load_addr`  in  AW  byte address of word to write; bits [1:0] ignored
- `load_data`  in  32  word to write, little-endian
- `inst`  out  32  fetched instruction
- `pc_out`  out  AW  byte address of `inst`
- `inst_valid`  out  1  `inst`/`pc_out` hold a valid fetch
- `fault`  out  1  sticky fetch fault, see Configuration
- `halted`  out  1  FSM is in HALT

## Operation
- Memory: `DEPTH_WORDS` x 32. Cleared to zero at time 0. Reset does not alter its contents. Word index = (addr − `BASE_ADDR`) >> 2, truncated to log2(`DEPTH_WORDS`) bits.
- Load port: when `load_we` is high, the addressed word is written at the clock edge. Writes are accepted in every state, including HALT and during stall. Loads with an out-of-window address are dropped when `IFETCH_BOUNDS_CHECK_EN` is defined; otherwise they wrap.
- FSM states:
  - BOOT: entered on reset; lasts exactly one cycle; no fetch; goes to RUN.
  - RUN: normal fetching.
  - HALT: entered on a fault; exits only on reset.
- RUN, per cycle, in priority order:
  1. If `redirect_valid`: PC <= `redirect_pc`; `inst_valid` <= 0 (squash). Redirect overrides stall.
  2. Else if `stall`: all outputs and PC hold.
  3. Else: `inst` <= mem[PC]; `pc_out` <= PC; `inst_valid` <= 1; PC <= PC + 4.
- PC arithmetic is AW bits, modulo 2^AW.
- Read-before-write: when a fetch and a load target the same word in the same cycle, the fetch returns the old data.
- Reset values:
  - PC = `BASE_ADDR`; FSM = BOOT.
  - `inst` = 0; `pc_out` = `BASE_ADDR`.
  - `inst_valid` = 0; `fault` = 0; `halted` = 0.

## Timing
- Fetch latency is 1 cycle: the PC presented at edge N yields `inst` after edge N.
- The first valid instruction (address `BASE_ADDR`) appears after the 2nd rising edge following reset deassertion (BOOT + fetch).
- After a redirect at edge N, `inst_valid` is 0 after edge N. The target instruction is valid after edge N+1, provided there is no stall.
- With `stall` held high, outputs are stable for any number of cycles. Fetch resumes on the first cycle `stall` is low.
- Reset asserted mid-operation: all registers take their reset values immediately (asynchronously). A load in the same cycle is discarded.
- On HALT entry: `inst_valid` = 0, `halted` = 1 and `fault` = 1, all on the same edge; outputs then hold until reset.

## Configuration
- Macro: `IFETCH_BOUNDS_CHECK_EN`.
- Defined: a fetch attempt in RUN with PC[1:0] ≠ 0, or with PC outside [`BASE_ADDR`, `BASE_ADDR` + 4·`DEPTH_WORDS`), performs no read. Instead it sets `fault`, clears `inst_valid` and moves the FSM to HALT. A redirect to a bad address faults on the following fetch cycle, not on the redirect edge.
- Not defined: no checks are made. Index bits wrap modulo `DEPTH_WORDS`, PC[1:0] is ignored for the read, and `fault` and `halted` are tied to 0.

## Test plan
- Reset, then load 0x11111111, 0x22222222, 0x33333333 at 0x00400000/4/8; run with no stall -> `inst_valid` rises 2 edges after reset release; `inst`/`pc_out` sequence 0x11111111@0x00400000, 0x22222222@0x00400004, 0x33333333@0x00400008.
- Assert `stall` for 3 cycles while 0x22222222 is valid -> `inst`, `pc_out` and `inst_valid` are unchanged for 3 cycles; 0x33333333 is valid on the cycle after stall drops.
- `redirect_valid` with `redirect_pc`=0x00400008 together with `stall`=1 -> `inst_valid`=0 on the next cycle, then 0x33333333@0x00400008 once stall drops.
- Load 0xDEADBEEF to the word being fetched in the same cycle -> old word is fetched; a redirect back to that word returns 0xDEADBEEF.
- With `IFETCH_BOUNDS_CHECK_EN`: redirect to 0x00400002, then to 0x00400000 + 4·`DEPTH_WORDS` (separate runs) -> `fault`=1, `halted`=1, `inst_valid`=0 and hold; loads are still accepted; reset clears all three.
- Without the macro: redirect to 0x00400000 + 4·`DEPTH_WORDS` -> fetches word 0 (0x11111111); `fault` stays 0.

Source files
------------

// File: rtl/ifetch_unit.sv
// ============================================================================
// Module   : ifetch_unit
// Purpose  : Front-end instruction fetch. Word-organised instruction memory,
//            program counter, registered instruction output with valid/stall
//            handshake, branch redirect, program-load port and a
//            BOOT/RUN/HALT sequencer.
// Ports    : clk, reset (async, active-high)
//            stall, redirect_valid, redirect_pc      - pipeline control
//            load_we, load_addr, load_data           - program-load port
//            inst, pc_out, inst_valid                - fetched instruction
//            fault, halted                           - sticky fetch fault
// Config   : IFETCH_BOUNDS_CHECK_EN - when defined, misaligned or
//            out-of-window fetches halt the unit and out-of-window loads are
//            dropped; otherwise addresses wrap and fault/halted stay 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_unit #(
    parameter int unsigned     AW          = 32,
    parameter logic [AW-1:0]   BASE_ADDR   = AW'(32'h0040_0000),
    parameter int unsigned     DEPTH_WORDS = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    output logic [31:0]   inst,
    output logic [AW-1:0] pc_out,
    output logic          inst_valid,
    output logic          fault,
    output logic          halted
);

    localparam int unsigned c_IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_pc;
    logic [AW-1:0]   r_pc_out;
    logic [31:0]     r_inst;
    logic            r_inst_valid;
    // fault and halted are always set together and only cleared by reset,
    // so a single flop drives both outputs.
    logic            r_fault;

    logic [31:0]     r_mem [DEPTH_WORDS] = '{default: '0};

    logic [c_IDX_W-1:0] w_fetch_idx;
    logic [c_IDX_W-1:0] w_load_idx;
    logic               w_fetch_ok;
    logic               w_load_ok;
    logic [31:0]        w_fetch_word;

`ifdef IFETCH_BOUNDS_CHECK_EN
    // Window test is done on the offset from BASE_ADDR: addresses below the
    // base wrap to large offsets and fail the same unsigned compare.
    localparam logic [AW:0] c_WIN_BYTES = (AW+1)'(4 * DEPTH_WORDS);

    logic [AW-1:0] w_fetch_off;
    logic [AW-1:0] w_load_off;

    assign w_fetch_off = r_pc - BASE_ADDR;
    assign w_load_off  = load_addr - BASE_ADDR;
    assign w_fetch_idx = w_fetch_off[c_IDX_W+1:2];
    assign w_load_idx  = w_load_off[c_IDX_W+1:2];
    assign w_fetch_ok  = (r_pc[1:0] == 2'b00) && ({1'b0, w_fetch_off} < c_WIN_BYTES);
    assign w_load_ok   = ({1'b0, w_load_off} < c_WIN_BYTES);
`else
    // No checking: index bits simply wrap modulo DEPTH_WORDS.
    assign w_fetch_idx = c_IDX_W'((r_pc - BASE_ADDR) >> 2);
    assign w_load_idx  = c_IDX_W'((load_addr - BASE_ADDR) >> 2);
    assign w_fetch_ok  = 1'b1;
    assign w_load_ok   = 1'b1;
`endif

    assign w_fetch_word = r_mem[w_fetch_idx];

    // The memory write lives in the reset-sensitive block so a load that
    // coincides with reset is discarded. Non-blocking update gives
    // read-before-write when a fetch and a load hit the same word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_BOOT;
            r_pc         <= BASE_ADDR;
            r_pc_out     <= BASE_ADDR;
            r_inst       <= 32'h0;
            r_inst_valid <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            if (load_we && w_load_ok) begin
                r_mem[w_load_idx] <= load_data;
            end

            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (redirect_valid) begin
                        // Redirect wins over stall and squashes the output.
                        r_pc         <= redirect_pc;
                        r_inst_valid <= 1'b0;
                    end else if (!stall) begin
                        if (!w_fetch_ok) begin
                            r_inst_valid <= 1'b0;
                            r_fault      <= 1'b1;
                            r_state      <= ST_HALT;
                        end else begin
                            r_inst       <= w_fetch_word;
                            r_pc_out     <= r_pc;
                            r_inst_valid <= 1'b1;
                            r_pc         <= r_pc + AW'(4);
                        end
                    end
                end
                ST_HALT: begin
                    // Outputs frozen until reset.
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

    assign inst       = r_inst;
    assign pc_out     = r_pc_out;
    assign inst_valid = r_inst_valid;
    assign fault      = r_fault;
    assign halted     = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// ============================================================================
// Module   : tb_ifetch_unit
// Purpose  : Self-checking bench for ifetch_unit: directed vector table,
//            hand-written corner sequences and a randomized run compared
//            against a behavioural model of fetch/stall/redirect/load.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifetch_unit;

    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam int          DEPTH = 16;
    localparam logic [31:0] WEND  = BASE + 32'(4 * DEPTH);
`ifdef IFETCH_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        load_we = 1'b0;
    logic [31:0] load_addr = 32'h0;
    logic [31:0] load_data = 32'h0;
    logic [31:0] inst;
    logic [31:0] pc_out;
    logic        inst_valid;
    logic        fault;
    logic        halted;

    ifetch_unit #(
        .AW          (32),
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .load_we        (load_we),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .inst           (inst),
        .pc_out         (pc_out),
        .inst_valid     (inst_valid),
        .fault          (fault),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc, m_inst, m_pcout;
    bit          m_valid, m_boot, m_halt;

    function automatic int widx(logic [31:0] a);
        return int'(((a - BASE) >> 2) % DEPTH);
    endfunction

    function automatic bit in_win(logic [31:0] a);
        return (a - BASE) < 32'(4 * DEPTH);
    endfunction

    function automatic logic [31:0] init_word(int i);
        if (i == 0) return 32'h1111_1111;
        if (i == 1) return 32'h2222_2222;
        if (i == 2) return 32'h3333_3333;
        return 32'hA000_0000 + 32'(i);
    endfunction

    task automatic model_reset();
        m_pc = BASE; m_inst = 32'h0; m_pcout = BASE;
        m_valid = 1'b0; m_boot = 1'b1; m_halt = 1'b0;
    endtask

    task automatic model_edge(bit s, bit rv, logic [31:0] rp, bit we,
                              logic [31:0] la, logic [31:0] ld);
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (!m_halt) begin
            if (rv) begin
                m_pc = rp;
                m_valid = 1'b0;
            end else if (!s) begin
                if (BC && (m_pc[1:0] != 2'b00 || !in_win(m_pc))) begin
                    m_halt = 1'b1;
                    m_valid = 1'b0;
                end else begin
                    m_inst  = m_mem[widx(m_pc)];
                    m_pcout = m_pc;
                    m_valid = 1'b1;
                    m_pc    = m_pc + 32'd4;
                end
            end
        end
        if (we && (!BC || in_win(la))) m_mem[widx(la)] = ld;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(string tag, bit v, logic [31:0] i, logic [31:0] p, bit f);
        check({tag, ".inst_valid"}, 32'(inst_valid), 32'(v));
        check({tag, ".inst"}, inst, i);
        check({tag, ".pc_out"}, pc_out, p);
        check({tag, ".fault"}, 32'(fault), 32'(f));
        check({tag, ".halted"}, 32'(halted), 32'(f));
    endtask

    task automatic check_model(string tag);
        check_outs(tag, m_valid, m_inst, m_pcout, m_halt);
    endtask

    // One clock: drive inputs, take the edge, update model, sample at +1.
    task automatic cycle(bit s, bit rv, logic [31:0] rp, bit we,
                         logic [31:0] la, logic [31:0] ld);
        stall = s; redirect_valid = rv; redirect_pc = rp;
        load_we = we; load_addr = la; load_data = ld;
        @(posedge clk);
        model_edge(s, rv, rp, we, la, ld);
        #1;
    endtask

    // Assert reset between edges (async check), with a load attempt that
    // must be discarded, then release just after an edge.
    task automatic do_reset(string tag);
        @(negedge clk);
        reset = 1'b1;
        load_we = 1'b1; load_addr = BASE + 32'd20; load_data = 32'hBAD0_BAD0;
        stall = 1'b0; redirect_valid = 1'b0;
        #1;
        model_reset();
        check_outs(tag, 1'b0, 32'h0, BASE, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        load_we = 1'b0;
    endtask

    typedef struct {
        bit          s;
        bit          rv;
        logic [31:0] rp;
        bit          we;
        logic [31:0] la;
        logic [31:0] ld;
        bit          ev;
        logic [31:0] ei;
        logic [31:0] ep;
        bit          ef;
    } vec_t;

    vec_t vecs[16];

    initial begin
        // ---- directed table, starting right after reset release ----
        vecs[0]  = '{0,0,0,0,0,0, 0, 32'h0,          BASE,          0}; // BOOT
        vecs[1]  = '{0,0,0,0,0,0, 1, 32'h1111_1111,  BASE,          0};
        vecs[2]  = '{0,0,0,0,0,0, 1, 32'h2222_2222,  BASE+4,        0};
        vecs[3]  = '{1,0,0,0,0,0, 1, 32'h2222_2222,  BASE+4,        0};
        vecs[4]  = '{1,0,0,0,0,0, 1, 32'h2222_2222,  BASE+4,        0};
        vecs[5]  = '{1,0,0,0,0,0, 1, 32'h2222_2222,  BASE+4,        0};
        vecs[6]  = '{0,0,0,0,0,0, 1, 32'h3333_3333,  BASE+8,        0};
        vecs[7]  = '{1,1,BASE+8,0,0,0, 0, 32'h3333_3333, BASE+8,    0}; // redirect+stall
        vecs[8]  = '{1,0,0,0,0,0, 0, 32'h3333_3333,  BASE+8,        0};
        vecs[9]  = '{0,0,0,0,0,0, 1, 32'h3333_3333,  BASE+8,        0};
        vecs[10] = '{0,0,0,1,BASE+12,32'hDEAD_BEEF, 1, 32'hA000_0003, BASE+12, 0};
        vecs[11] = '{0,1,BASE+12,0,0,0, 0, 32'hA000_0003, BASE+12,  0};
        vecs[12] = '{0,0,0,0,0,0, 1, 32'hDEAD_BEEF,  BASE+12,       0};
        vecs[13] = '{0,1,WEND,0,0,0, 0, 32'hDEAD_BEEF, BASE+12,     0};
        vecs[14] = '{0,0,0,0,0,0, !BC, BC ? 32'hDEAD_BEEF : 32'h1111_1111,
                     BC ? BASE+12 : WEND, BC};
        vecs[15] = '{0,0,0,0,0,0, !BC, BC ? 32'hDEAD_BEEF : 32'h2222_2222,
                     BC ? BASE+12 : WEND+4, BC};

        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;

        do_reset("rst0");

        // Program load while the pipeline is stalled.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b1, BASE + 32'(4 * i), init_word(i));
            check_model($sformatf("load%0d", i));
        end

        do_reset("rst1");
        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].s, vecs[i].rv, vecs[i].rp, vecs[i].we, vecs[i].la, vecs[i].ld);
            check_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ei, vecs[i].ep, vecs[i].ef);
        end

        // ---- misaligned redirect; a load is issued after the bad fetch ----
        do_reset("rst2");
        cycle(0, 0, 32'h0, 0, 32'h0, 32'h0);                           // BOOT
        cycle(0, 1, BASE + 32'd2, 0, 32'h0, 32'h0);
        check_outs("misal.redir", 1'b0, 32'h0, BASE, 1'b0);
        cycle(0, 0, 32'h0, 0, 32'h0, 32'h0);
        check_outs("misal.fetch", !BC, BC ? 32'h0 : 32'h1111_1111, BC ? BASE : BASE + 32'd2, BC);
        cycle(0, 0, 32'h0, 1, BASE + 32'd16, 32'h5555_5555);
        check_outs("misal.next", !BC, BC ? 32'h0 : 32'h2222_2222, BC ? BASE : BASE + 32'd6, BC);
        cycle(1, 1, BASE, 0, 32'h0, 32'h0);
        check_outs("misal.hold", 1'b0, BC ? 32'h0 : 32'h2222_2222, BC ? BASE : BASE + 32'd6, BC);

        // Load from the previous run must be visible; reset clears the fault.
        do_reset("rst3");
        cycle(0, 0, 32'h0, 0, 32'h0, 32'h0);                           // BOOT
        cycle(0, 1, BASE + 32'd16, 0, 32'h0, 32'h0);
        cycle(0, 0, 32'h0, 0, 32'h0, 32'h0);
        check_outs("loadchk", 1'b1, 32'h5555_5555, BASE + 32'd16, 1'b0);

        // ---- randomized run against the model ----
        for (int blk = 0; blk < 6; blk++) begin
            do_reset($sformatf("rrst%0d", blk));
            for (int n = 0; n < 60; n++) begin
                bit          s, rv, we;
                logic [31:0] rp, la;
                s  = ($urandom_range(0, 2) == 0);
                rv = ($urandom_range(0, 7) == 0);
                rp = ($urandom_range(0, 3) == 0) ? $urandom
                     : BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
                we = ($urandom_range(0, 3) == 0);
                la = ($urandom_range(0, 3) == 0) ? $urandom
                     : BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
                cycle(s, rv, rp, we, la, $urandom);
                check_model($sformatf("rnd%0d_%0d", blk, n));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the bench always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
